// File: rtl/memory_arbiter_if.sv
// -----------------------------------------------------------------------------
// memory_arbiter_if
//
// Purpose:
//   Bundles every handshake and memory-bus signal of the two-requester memory
//   arbiter. clk and reset are kept outside the bundle as plain ports.
//
// Parameters:
//   ADDR_WIDTH - address width of both requesters and of the memory bus
//   DATA_WIDTH - data width of both requesters and of the memory bus
//
// Signals (the direction shown is as seen by the arbiter, modport slave):
//   req_0/we_0/addr_0/wdata_0  in   requester 0 (CPU) request
//   ack_0/rdata_0              out  requester 0 completion pulse and read data
//   req_1/we_1/addr_1/wdata_1  in   requester 1 (loader/DMA) request
//   ack_1/rdata_1/err_1        out  requester 1 completion, read data, protection flag
//   mem_address/mem_data_in    out  address and write data to the memory block
//   mem_write                  out  single-cycle memory write strobe
//   mem_data_out               in   read data returned by the memory block
//   busy                       out  arbiter is not idle
//   grant_id                   out  owner of the current or most recent transaction
//
// Modports:
//   slave  - the arbiter side
//   master - the side that drives requests and plays the memory block
// -----------------------------------------------------------------------------
interface memory_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    // Requester 0
    logic                  req_0;
    logic                  we_0;
    logic [ADDR_WIDTH-1:0] addr_0;
    logic [DATA_WIDTH-1:0] wdata_0;
    logic                  ack_0;
    logic [DATA_WIDTH-1:0] rdata_0;

    // Requester 1
    logic                  req_1;
    logic                  we_1;
    logic [ADDR_WIDTH-1:0] addr_1;
    logic [DATA_WIDTH-1:0] wdata_1;
    logic                  ack_1;
    logic [DATA_WIDTH-1:0] rdata_1;
    logic                  err_1;

    // Memory side
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] mem_data_out;

    // Status
    logic                  busy;
    logic                  grant_id;

    modport slave (
        input  req_0, we_0, addr_0, wdata_0,
        input  req_1, we_1, addr_1, wdata_1,
        input  mem_data_out,
        output ack_0, rdata_0,
        output ack_1, rdata_1, err_1,
        output mem_address, mem_data_in, mem_write,
        output busy, grant_id
    );

    modport master (
        output req_0, we_0, addr_0, wdata_0,
        output req_1, we_1, addr_1, wdata_1,
        output mem_data_out,
        input  ack_0, rdata_0,
        input  ack_1, rdata_1, err_1,
        input  mem_address, mem_data_in, mem_write,
        input  busy, grant_id
    );
endinterface

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//
// Purpose:
//   Two-requester arbiter and sequencer placed in front of the 8-bit memory
//   block (ROM 0x00-0x7F, RAM 0x80-0xDF, output ports 0xE0-0xEF, input ports
//   0xF0-0xFF). Requester 0 is the CPU, requester 1 the program loader/DMA.
//   Accesses are serialised through IDLE -> ISSUE -> [WAIT] -> DONE: a write
//   becomes a single-cycle mem_write strobe in ISSUE, a read waits out the
//   memory read latency, and each transaction ends with a one-cycle ack pulse
//   to its owner. When both requesters are pending, the one that was not
//   granted last time wins, so continuous traffic alternates 0,1,0,1.
//
// Parameters:
//   ADDR_WIDTH   - address width (default 8)
//   DATA_WIDTH   - data width (default 8)
//   READ_LATENCY - clocks from address issue to valid mem_data_out (0..7)
//
// Ports:
//   clk    in   system clock, everything on the rising edge
//   reset  in   synchronous, active-high reset
//   bus    -    memory_arbiter_if.slave: both requester channels, the memory
//               bus, busy and grant_id
//
// Build option:
//   PORT_PROTECT_EN - when defined, a write from requester 1 to ROM
//                     (0x00-0x7F) or to the output ports (0xE0-0xEF) is not
//                     strobed to memory; the transaction still completes and
//                     ack_1 is accompanied by err_1 = 1. When undefined, err_1
//                     is tied low and no write is ever blocked.
// -----------------------------------------------------------------------------
module memory_arbiter #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic            clk,
    input  logic            reset,
    memory_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Value loaded into the latency counter when a read leaves ISSUE. The
    // counter counts the remaining WAIT cycles after the current one, so a
    // latency of L spends exactly L cycles in WAIT.
    localparam logic [2:0] LAT_LOAD = 3'((READ_LATENCY > 0) ? (READ_LATENCY - 1) : 0);
    localparam bit         LAT_ZERO = (READ_LATENCY == 0);

    // -------------------------------------------------------------------------
    // Requester inputs gathered into indexable form
    // -------------------------------------------------------------------------
    logic [1:0]            req_w;
    logic [1:0]            we_w;
    logic [ADDR_WIDTH-1:0] addr_w  [2];
    logic [DATA_WIDTH-1:0] wdata_w [2];

    assign req_w      = {bus.req_1, bus.req_0};
    assign we_w       = {bus.we_1, bus.we_0};
    assign addr_w[0]  = bus.addr_0;
    assign addr_w[1]  = bus.addr_1;
    assign wdata_w[0] = bus.wdata_0;
    assign wdata_w[1] = bus.wdata_1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                state_q,   state_d;
    // grant_q doubles as last_grant: both are updated together on every
    // arbitration and both reset to 1, so they can never differ.
    logic                  grant_q,   grant_d;
    logic                  we_q,      we_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [2:0]            cnt_q,     cnt_d;
    logic                  blocked_q, blocked_d;

    logic                  win_w;        // arbitration winner in IDLE
    logic                  protect_hit;  // requester 1 address lies in a protected region
    logic                  capture_w;    // sample mem_data_out on this edge (entering DONE on a read)
    logic [1:0]            ack_w;

    // -------------------------------------------------------------------------
    // Protection decode for requester 1
    // -------------------------------------------------------------------------
`ifdef PORT_PROTECT_EN
    localparam logic [ADDR_WIDTH-1:0] ROM_LAST  = ADDR_WIDTH'('h7F);
    localparam logic [ADDR_WIDTH-1:0] OUT_FIRST = ADDR_WIDTH'('hE0);
    localparam logic [ADDR_WIDTH-1:0] OUT_LAST  = ADDR_WIDTH'('hEF);

    assign protect_hit = (addr_w[1] <= ROM_LAST) ||
                         ((addr_w[1] >= OUT_FIRST) && (addr_w[1] <= OUT_LAST));
`else
    assign protect_hit = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Arbitration: a sole requester wins; on a tie the one that was not
    // granted last wins.
    // -------------------------------------------------------------------------
    always_comb begin
        win_w = 1'b0;
        if (req_w[0] && req_w[1]) begin
            win_w = ~grant_q;
        end else if (req_w[1]) begin
            win_w = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= 3'd0;
            blocked_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            blocked_q <= blocked_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        blocked_d = blocked_q;
        capture_w = 1'b0;

        case (state_q)
            IDLE: begin
                // Requests that arrived while busy are simply still high
                // here, so nothing is ever dropped.
                if (|req_w) begin
                    grant_d   = win_w;
                    we_d      = we_w[win_w];
                    addr_d    = addr_w[win_w];
                    wdata_d   = wdata_w[win_w];
                    blocked_d = win_w & we_w[1] & protect_hit;
                    state_d   = ISSUE;
                end
            end

            ISSUE: begin
                if (we_q || LAT_ZERO) begin
                    // A zero-latency memory already presents read data
                    // during ISSUE, so it is captured on the way to DONE.
                    capture_w = ~we_q;
                    state_d   = DONE;
                end else begin
                    cnt_d   = LAT_LOAD;
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (cnt_q == 3'd0) begin
                    capture_w = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Per-requester ack and read-data holding registers. rdata only changes
    // when a read for that requester completes, so it holds across writes.
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rdata_q [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign ack_w[gi] = (state_q == DONE) && (grant_q == 1'(gi));

            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_q[gi] <= '0;
                end else if (capture_w && (grant_q == 1'(gi))) begin
                    rdata_q[gi] <= bus.mem_data_out;
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.ack_0       = ack_w[0];
    assign bus.ack_1       = ack_w[1];
    assign bus.rdata_0     = rdata_q[0];
    assign bus.rdata_1     = rdata_q[1];
    assign bus.mem_address = addr_q;
    assign bus.mem_data_in = wdata_q;
    // The strobe lasts exactly the single ISSUE cycle; a blocked write runs
    // through the same states with the strobe suppressed.
    assign bus.mem_write   = (state_q == ISSUE) && we_q && !blocked_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.grant_id    = grant_q;

`ifdef PORT_PROTECT_EN
    assign bus.err_1 = ack_w[1] && blocked_q;
`else
    assign bus.err_1 = 1'b0;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_memory_arbiter
//
// Bench for memory_arbiter. Provides a memory block stub (ROM pattern, RAM,
// output ports, input ports, one-cycle read latency), a table of single
// transactions, hand-written multi-cycle sequences and a randomized phase
// with both requesters held busy, checked against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int LAT = 1;

`ifdef PORT_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic mem_clear;

    always #5 clk = ~clk;

    memory_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    memory_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .READ_LATENCY(LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // ---------------------------------------------------------------- memory
    function automatic logic [7:0] rom_val(input logic [7:0] a);
        return a ^ 8'hA5;
    endfunction

    function automatic logic [7:0] pin_val(input logic [7:0] a);
        return 8'hAA + {4'h0, a[3:0]};
    endfunction

    logic [7:0] mem [256];

    function automatic logic [7:0] stub_read(input logic [7:0] a);
        if (a < 8'h80)       return rom_val(a);
        else if (a >= 8'hF0) return pin_val(a);
        else                 return mem[a];
    endfunction

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (bus.mem_write && bus.mem_address >= 8'h80 && bus.mem_address < 8'hF0) begin
            mem[bus.mem_address] <= bus.mem_data_in;
        end
        bus.mem_data_out <= stub_read(bus.mem_address);
    end

    // ------------------------------------------------------- reference model
    logic [7:0] exp_mem [256];
    logic [7:0] exp_last_rd [2];

    function automatic logic blocked_exp(input logic id, input logic we, input logic [7:0] a);
        return PROT && id && we && ((a < 8'h80) || (a[7:4] == 4'hE));
    endfunction

    function automatic logic [7:0] exp_read(input logic [7:0] a);
        if (a < 8'h80)       return rom_val(a);
        else if (a >= 8'hF0) return pin_val(a);
        else                 return exp_mem[a];
    endfunction

    task automatic model_write(input logic id, input logic [7:0] a, input logic [7:0] d);
        if (!blocked_exp(id, 1'b1, a) && a >= 8'h80 && a < 8'hF0) exp_mem[a] = d;
    endtask

    function automatic int lat_of(input logic we);
        return we ? 2 : 2 + LAT;
    endfunction

    // ---------------------------------------------------------------- checks
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic id, input logic r, input logic we,
                         input logic [7:0] a, input logic [7:0] d);
        if (id == 1'b0) begin
            bus.req_0 = r; bus.we_0 = we; bus.addr_0 = a; bus.wdata_0 = d;
        end else begin
            bus.req_1 = r; bus.we_1 = we; bus.addr_1 = a; bus.wdata_1 = d;
        end
    endtask

    function automatic logic [37:0] out_vec();
        return {bus.ack_0, bus.ack_1, bus.rdata_0, bus.rdata_1, bus.err_1,
                bus.mem_write, bus.mem_address, bus.mem_data_in, bus.busy, bus.grant_id};
    endfunction

    // Reset values: everything zero except grant_id = 1.
    localparam logic [37:0] RESET_VEC = 38'h1;

    // Single transaction from an idle arbiter; called at a negedge.
    task automatic run_txn(input string tag, input logic id, input logic we,
                           input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] exp_rd, input logic exp_err);
        int lat_exp = lat_of(we);
        int ack_at = 0, wr_cnt = 0, wr_at = 0, busy_cnt = 0;
        logic other_ack = 1'b0;
        logic [7:0] rd = 8'h00;
        logic er = 1'b0;
        logic blk = blocked_exp(id, we, a);

        drive(id, 1'b1, we, a, d);
        for (int i = 1; i <= lat_exp + 4; i++) begin
            @(negedge clk);
            if (bus.mem_write) begin
                wr_cnt++;
                if (wr_at == 0) wr_at = i;
                check({tag, "_wr_bus"}, {bus.mem_address, bus.mem_data_in}, {a, d});
            end
            if (bus.busy) busy_cnt++;
            if (id ? bus.ack_0 : bus.ack_1) other_ack = 1'b1;
            if (id ? bus.ack_1 : bus.ack_0) begin
                ack_at = i;
                rd = id ? bus.rdata_1 : bus.rdata_0;
                er = bus.err_1;
                break;
            end
        end
        drive(id, 1'b0, we, a, d);

        check({tag, "_ack_latency"}, ack_at, lat_exp);
        check({tag, "_busy_cycles"}, busy_cnt, lat_exp);
        check({tag, "_other_ack"}, other_ack, 1'b0);
        check({tag, "_wr_count"}, wr_cnt, (we && !blk) ? 1 : 0);
        check({tag, "_wr_cycle"}, wr_at, (we && !blk) ? 1 : 0);
        if (we) begin
            check({tag, "_rdata_hold"}, rd, exp_last_rd[id]);
            model_write(id, a, d);
        end else begin
            check({tag, "_rdata"}, rd, exp_rd);
            exp_last_rd[id] = exp_rd;
        end
        if (id) check({tag, "_err1"}, er, exp_err);
        $display("txn %s: req%0d %s addr=%02h wdata=%02h rdata=%02h err=%0d ack_after=%0d",
                 tag, id, we ? "WR" : "RD", a, d, rd, er, ack_at);

        @(negedge clk);
        check({tag, "_idle_after"}, bus.busy, 1'b0);
    endtask

    task automatic do_reset(input logic clear_mem);
        reset = 1'b1;
        mem_clear = clear_mem;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        @(negedge clk);
        check("reset_values", out_vec(), RESET_VEC);
        reset = 1'b0;
        mem_clear = 1'b0;
        exp_last_rd[0] = 8'h00;
        exp_last_rd[1] = 8'h00;
    endtask

    // ------------------------------------------------------------- vectors
    typedef struct {
        string      tag;
        logic       id;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        logic       exp_err;
    } vec_t;

    typedef struct {
        logic       we;
        logic [7:0] a;
        logic [7:0] d;
    } op_t;

    function automatic op_t rand_op();
        op_t o;
        int region = $urandom_range(0, 3);
        o.we = 1'($urandom_range(0, 1));
        o.d  = 8'($urandom);
        case (region)
            0:       o.a = 8'h80 + 8'($urandom_range(0, 15));
            1:       o.a = 8'($urandom_range(0, 127));
            2:       o.a = 8'hE0 + 8'($urandom_range(0, 15));
            default: o.a = 8'hF0 + 8'($urandom_range(0, 15));
        endcase
        return o;
    endfunction

    vec_t vecs[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"w82",   1'b0, 1'b1, 8'h82, 8'h55, 8'h00, 1'b0};
        vecs[1]  = '{"r82",   1'b0, 1'b0, 8'h82, 8'h00, 8'h55, 1'b0};
        vecs[2]  = '{"rF0",   1'b0, 1'b0, 8'hF0, 8'h00, 8'hAA, 1'b0};
        vecs[3]  = '{"w90",   1'b1, 1'b1, 8'h90, 8'h12, 8'h00, 1'b0};
        vecs[4]  = '{"r90",   1'b1, 1'b0, 8'h90, 8'h00, 8'h12, 1'b0};
        vecs[5]  = '{"r05",   1'b0, 1'b0, 8'h05, 8'h00, 8'hA0, 1'b0};
        vecs[6]  = '{"w1E0",  1'b1, 1'b1, 8'hE0, 8'h33, 8'h00, PROT};
        vecs[7]  = '{"rE0",   1'b0, 1'b0, 8'hE0, 8'h00, PROT ? 8'h00 : 8'h33, 1'b0};
        vecs[8]  = '{"w1rom", 1'b1, 1'b1, 8'h10, 8'h77, 8'h00, PROT};
        vecs[9]  = '{"w1DF",  1'b1, 1'b1, 8'hDF, 8'h99, 8'h00, 1'b0};
        vecs[10] = '{"r1DF",  1'b1, 1'b0, 8'hDF, 8'h00, 8'h99, 1'b0};
        vecs[11] = '{"w0EF",  1'b0, 1'b1, 8'hEF, 8'h44, 8'h00, 1'b0};
        vecs[12] = '{"r1FF",  1'b1, 1'b0, 8'hFF, 8'h00, 8'hB9, 1'b0};

        for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;

        // Reset state
        do_reset(1'b1);

        // Table of single transactions
        for (int i = 0; i < 13; i++) begin
            run_txn(vecs[i].tag, vecs[i].id, vecs[i].we, vecs[i].addr,
                    vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err);
        end
        check("port_out_00", mem[8'hE0], PROT ? 8'h00 : 8'h33);

        // Requester 1 arrives while a requester-0 read sits in WAIT; it must
        // reach ISSUE two cycles after ack_0, via one IDLE cycle.
        drive(1'b0, 1'b1, 1'b0, 8'h82, 8'h00);           // cycle c0 (IDLE)
        @(negedge clk);                                   // c0+1 ISSUE
        @(negedge clk);                                   // c0+2 WAIT
        check("pend_wait_busy", {bus.busy, bus.grant_id}, 2'b10);
        drive(1'b1, 1'b1, 1'b0, 8'h90, 8'h00);
        @(negedge clk);                                   // c0+3 DONE
        check("pend_ack0", {bus.ack_0, bus.ack_1, bus.rdata_0}, {2'b10, 8'h55});
        drive(1'b0, 1'b0, 1'b0, 8'h82, 8'h00);
        @(negedge clk);                                   // c0+4 IDLE
        check("pend_idle", bus.busy, 1'b0);
        @(negedge clk);                                   // c0+5 ISSUE for req1
        check("pend_issue1", {bus.busy, bus.grant_id, bus.mem_address}, {2'b11, 8'h90});
        @(negedge clk);                                   // c0+6 WAIT
        @(negedge clk);                                   // c0+7 DONE
        check("pend_ack1", {bus.ack_0, bus.ack_1, bus.rdata_1}, {2'b01, 8'h12});
        drive(1'b1, 1'b0, 1'b0, 8'h90, 8'h00);
        $display("txn pend: req0 RD 82 then req1 RD 90 rdata0=%02h rdata1=%02h",
                 bus.rdata_0, bus.rdata_1);
        exp_last_rd[0] = 8'h55;
        exp_last_rd[1] = 8'h12;
        @(negedge clk);

        // Reset pulsed during the WAIT of a read: no ack, reset values next.
        begin
            logic any_ack = 1'b0;
            drive(1'b0, 1'b1, 1'b0, 8'h82, 8'h00);        // c0 IDLE
            @(negedge clk);                               // c0+1 ISSUE
            @(negedge clk);                               // c0+2 WAIT
            reset = 1'b1;
            drive(1'b0, 1'b0, 1'b0, 8'h82, 8'h00);
            @(negedge clk);                               // c0+3 after reset edge
            check("midreset_values", out_vec(), RESET_VEC);
            reset = 1'b0;
            exp_last_rd[0] = 8'h00;
            exp_last_rd[1] = 8'h00;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (bus.ack_0 || bus.ack_1 || bus.busy) any_ack = 1'b1;
            end
            check("midreset_quiet", any_ack, 1'b0);
            $display("txn midreset: req0 RD 82 abandoned by reset");
        end
        run_txn("r82_after_reset", 1'b0, 1'b0, 8'h82, 8'h00, 8'h55, 1'b0);

        // Randomized phase: both requesters keep req high and present a new
        // access right after each ack. Grants must alternate starting with 0,
        // each ack lands exactly at sample cycle + 2 (+ latency for reads).
        begin
            op_t  op [2];
            logic w = 1'b0;
            int   cyc = 0;
            int   done_n = 0;
            int   exp_ack;
            int   wr_seen = 0;
            int   wr_exp = 0;
            logic [1:0] exp_ack_vec;
            logic [7:0] rd;
            logic [7:0] exp_rd;

            do_reset(1'b0);
            op[0] = rand_op();
            op[1] = rand_op();
            drive(1'b0, 1'b1, op[0].we, op[0].a, op[0].d);
            drive(1'b1, 1'b1, op[1].we, op[1].a, op[1].d);
            exp_ack = lat_of(op[0].we);

            while (done_n < 60 && cyc < 2000) begin
                @(negedge clk);
                cyc++;
                if (bus.mem_write) wr_seen++;
                exp_ack_vec = (cyc == exp_ack) ? (w ? 2'b01 : 2'b10) : 2'b00;
                check("rand_acks", {bus.ack_0, bus.ack_1}, exp_ack_vec);
                if (cyc == exp_ack) begin
                    check("rand_grant_id", bus.grant_id, w);
                    rd = w ? bus.rdata_1 : bus.rdata_0;
                    exp_rd = op[w].we ? exp_last_rd[w] : exp_read(op[w].a);
                    check("rand_rdata", rd, exp_rd);
                    if (w) check("rand_err1", bus.err_1, blocked_exp(1'b1, op[1].we, op[1].a));
                    if (op[w].we) begin
                        model_write(w, op[w].a, op[w].d);
                        if (!blocked_exp(w, 1'b1, op[w].a)) wr_exp++;
                    end else begin
                        exp_last_rd[w] = exp_rd;
                    end
                    $display("txn rand%0d: req%0d %s addr=%02h wdata=%02h rdata=%02h cycle=%0d",
                             done_n, w, op[w].we ? "WR" : "RD", op[w].a, op[w].d, rd, cyc);
                    op[w] = rand_op();
                    drive(w, 1'b1, op[w].we, op[w].a, op[w].d);
                    w = ~w;
                    exp_ack = cyc + 1 + lat_of(op[w].we);
                    done_n++;
                end
            end
            drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
            check("rand_completed", done_n, 60);
            check("rand_write_strobes", wr_seen, wr_exp);
            @(negedge clk);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
